// File: rtl/tail_light_seq.sv
// Turn / hazard / brake tail-light sequencer with LAMPS lamps per side.
// A step-rate prescaler lets the lamp patterns advance slower than CLK.
module tail_light_seq #(
  parameter int LAMPS = 3,
  parameter int DIV   = 1
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             L,
  input  logic             R,
  input  logic             Haz,
  input  logic             Brake,
  output logic [LAMPS-1:0] Lout,
  output logic [LAMPS-1:0] Rout,
  output logic             Active
);

  localparam int SW = $clog2(LAMPS + 1);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [SW-1:0] STEP_LAST = SW'(LAMPS);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_LEFT, S_RIGHT, S_HAZ} state_t;

  state_t          r_state, w_state_next, w_dec_state;
  logic [SW-1:0]   r_step, w_step_next, w_dec_step;
  logic [CW-1:0]   r_cnt;
  logic [LAMPS-1:0] r_lout, r_rout, w_lout_next, w_rout_next;
  logic [LAMPS-1:0] w_therm, w_therm_rev;
  logic            w_tick, w_haz_req;

  assign w_tick    = (r_cnt == CNT_LAST);
  assign w_haz_req = (L & R) | Haz;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_cnt   <= '0;
      r_state <= S_IDLE;
      r_step  <= '0;
      r_lout  <= '0;
      r_rout  <= '0;
    end else begin
      r_cnt   <= w_tick ? '0 : r_cnt + CW'(1);
      r_state <= w_state_next;
      r_step  <= w_step_next;
      r_lout  <= w_lout_next;
      r_rout  <= w_rout_next;
    end
  end

  // Decision taken from IDLE, and also used when a running sweep is aborted.
  always_comb begin
    w_dec_state = S_IDLE;
    w_dec_step  = '0;
    if (w_haz_req) begin
      w_dec_state = S_HAZ;
      w_dec_step  = SW'(1);
    end else if (L) begin
      w_dec_state = S_LEFT;
      w_dec_step  = SW'(1);
    end else if (R) begin
      w_dec_state = S_RIGHT;
      w_dec_step  = SW'(1);
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_step_next  = r_step;
    if (w_tick) begin
      case (r_state)
        S_IDLE: begin
          w_state_next = w_dec_state;
          w_step_next  = w_dec_step;
        end
        S_LEFT: begin
          if (R | Haz) begin
            w_state_next = w_dec_state;
            w_step_next  = w_dec_step;
          end else if (r_step == STEP_LAST) begin
            w_state_next = S_IDLE;
            w_step_next  = '0;
          end else begin
            w_step_next  = r_step + SW'(1);
          end
        end
        S_RIGHT: begin
          if (L | Haz) begin
            w_state_next = w_dec_state;
            w_step_next  = w_dec_step;
          end else if (r_step == STEP_LAST) begin
            w_state_next = S_IDLE;
            w_step_next  = '0;
          end else begin
            w_step_next  = r_step + SW'(1);
          end
        end
        S_HAZ: begin
          if (w_haz_req) begin
            w_step_next  = (r_step == '0) ? SW'(1) : '0;
          end else begin
            w_state_next = S_IDLE;
            w_step_next  = '0;
          end
        end
        default: begin
          w_state_next = S_IDLE;
          w_step_next  = '0;
        end
      endcase
    end
  end

  // Thermometer of the upcoming step; the right side is its mirror image.
  generate
    for (genvar gi = 0; gi < LAMPS; gi++) begin : g_therm
      assign w_therm[gi]     = (SW'(gi) < w_step_next);
      assign w_therm_rev[gi] = w_therm[LAMPS-1-gi];
    end
  endgenerate

  always_comb begin
    w_lout_next = Brake ? '1 : '0;
    w_rout_next = Brake ? '1 : '0;
    case (w_state_next)
      S_LEFT:  w_lout_next = w_therm;
      S_RIGHT: w_rout_next = w_therm_rev;
      S_HAZ: begin
        w_lout_next = (w_step_next != '0) ? '1 : '0;
        w_rout_next = (w_step_next != '0) ? '1 : '0;
      end
      default: ;
    endcase
  end

  assign Lout   = r_lout;
  assign Rout   = r_rout;
  assign Active = (r_state != S_IDLE);

endmodule

// File: tb/tb_tail_light_seq.sv
// Bench for tail_light_seq: three parameterisations share one set of inputs,
// each checked every cycle against a rule-level model, plus literal directed sequences.
module tb_tail_light_seq;

  localparam int NI = 3;
  localparam int M_IDLE = 0, M_LEFT = 1, M_RIGHT = 2, M_HAZ = 3;

  logic CLK = 1'b0;
  logic Reset = 1'b1, L = 1'b0, R = 1'b0, Haz = 1'b0, Brake = 1'b0;
  logic [2:0] lo0, ro0, lo1, ro1;
  logic [4:0] lo2, ro2;
  logic       a0, a1, a2;

  int n_cmp = 0;
  int n_bad = 0;

  int k_lamps [NI] = '{3, 3, 5};
  int k_div   [NI] = '{1, 4, 2};
  int m_mode  [NI] = '{0, 0, 0};
  int m_step  [NI] = '{0, 0, 0};
  int m_cnt   [NI] = '{0, 0, 0};
  int m_l     [NI] = '{0, 0, 0};
  int m_r     [NI] = '{0, 0, 0};

  tail_light_seq #(.LAMPS(3), .DIV(1)) u0 (
    .CLK(CLK), .Reset(Reset), .L(L), .R(R), .Haz(Haz), .Brake(Brake),
    .Lout(lo0), .Rout(ro0), .Active(a0));
  tail_light_seq #(.LAMPS(3), .DIV(4)) u1 (
    .CLK(CLK), .Reset(Reset), .L(L), .R(R), .Haz(Haz), .Brake(Brake),
    .Lout(lo1), .Rout(ro1), .Active(a1));
  tail_light_seq #(.LAMPS(5), .DIV(2)) u2 (
    .CLK(CLK), .Reset(Reset), .L(L), .R(R), .Haz(Haz), .Brake(Brake),
    .Lout(lo2), .Rout(ro2), .Active(a2));

  always #5 CLK = ~CLK;

  function automatic int dut_l(input int k);
    return (k == 0) ? int'(lo0) : (k == 1) ? int'(lo1) : int'(lo2);
  endfunction
  function automatic int dut_r(input int k);
    return (k == 0) ? int'(ro0) : (k == 1) ? int'(ro1) : int'(ro2);
  endfunction
  function automatic int dut_a(input int k);
    return (k == 0) ? int'(a0) : (k == 1) ? int'(a1) : int'(a2);
  endfunction

  // Start a new request: hazard (or both turns) wins, then left, then right.
  task automatic start_req(input int k);
    if ((L && R) || Haz) begin m_mode[k] = M_HAZ;   m_step[k] = 1; end
    else if (L)          begin m_mode[k] = M_LEFT;  m_step[k] = 1; end
    else if (R)          begin m_mode[k] = M_RIGHT; m_step[k] = 1; end
    else                 begin m_mode[k] = M_IDLE;  m_step[k] = 0; end
  endtask

  task automatic model_edge(input int k);
    int full, bk, n;
    bit tick;
    n    = k_lamps[k];
    full = (1 << n) - 1;
    if (Reset) begin
      m_mode[k] = M_IDLE; m_step[k] = 0; m_cnt[k] = 0; m_l[k] = 0; m_r[k] = 0;
      return;
    end
    tick = (m_cnt[k] == k_div[k] - 1);
    m_cnt[k] = tick ? 0 : m_cnt[k] + 1;
    if (tick) begin
      if (m_mode[k] == M_IDLE) start_req(k);
      else if (m_mode[k] == M_HAZ) begin
        if ((L && R) || Haz) m_step[k] = 1 - m_step[k];
        else begin m_mode[k] = M_IDLE; m_step[k] = 0; end
      end else if ((m_mode[k] == M_LEFT && (R || Haz)) ||
                   (m_mode[k] == M_RIGHT && (L || Haz))) start_req(k);
      else if (m_step[k] == n) begin m_mode[k] = M_IDLE; m_step[k] = 0; end
      else m_step[k] = m_step[k] + 1;
    end
    bk = Brake ? full : 0;
    m_l[k] = bk;
    m_r[k] = bk;
    if (m_mode[k] == M_LEFT)  m_l[k] = (1 << m_step[k]) - 1;
    if (m_mode[k] == M_RIGHT) m_r[k] = ((1 << m_step[k]) - 1) << (n - m_step[k]);
    if (m_mode[k] == M_HAZ) begin
      m_l[k] = (m_step[k] != 0) ? full : 0;
      m_r[k] = m_l[k];
    end
  endtask

  // Every-cycle compare process against the model.
  initial begin
    forever begin
      @(posedge CLK);
      for (int k = 0; k < NI; k++) model_edge(k);
      @(negedge CLK);
      for (int k = 0; k < NI; k++) begin
        n_cmp++;
        if (dut_l(k) != m_l[k] || dut_r(k) != m_r[k] || dut_a(k) != int'(m_mode[k] != M_IDLE)) begin
          n_bad++;
          $display("FAIL model_u%0d t=%0t got L=%0h R=%0h A=%0d exp L=%0h R=%0h A=%0d",
                   k, $time, dut_l(k), dut_r(k), dut_a(k), m_l[k], m_r[k], int'(m_mode[k] != M_IDLE));
        end
      end
    end
  end

  task automatic chk(input int k, input int el, input int er, input int ea, input string nm);
    @(posedge CLK);
    @(negedge CLK);
    n_cmp++;
    if (dut_l(k) != el || dut_r(k) != er || dut_a(k) != ea) begin
      n_bad++;
      $display("FAIL %s u%0d t=%0t got L=%0h R=%0h A=%0d exp L=%0h R=%0h A=%0d",
               nm, k, $time, dut_l(k), dut_r(k), dut_a(k), el, er, ea);
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1; L = 1'b0; R = 1'b0; Haz = 1'b0; Brake = 1'b0;
    chk(0, 0, 0, 0, "reset");
    Reset = 1'b0;
  endtask

  initial begin
    int t1l [8] = '{1, 3, 7, 0, 1, 3, 7, 0};
    int t1a [8] = '{1, 1, 1, 0, 1, 1, 1, 0};
    int t2r [5] = '{4, 6, 7, 0, 0};
    int t4  [4] = '{7, 0, 7, 0};

    // Left sweep held
    do_reset();
    L = 1'b1;
    for (int i = 0; i < 8; i++) chk(0, t1l[i], 0, t1a[i], "left_sweep");

    // Single-edge right request completes its sweep
    do_reset();
    R = 1'b1;
    chk(0, 0, t2r[0], 1, "right_pulse");
    R = 1'b0;
    for (int i = 1; i < 5; i++) chk(0, 0, t2r[i], int'(i < 3), "right_pulse");

    // Left aborted by right without an off gap
    do_reset();
    L = 1'b1;
    chk(0, 1, 0, 1, "abort_pre");
    chk(0, 3, 0, 1, "abort_pre");
    L = 1'b0; R = 1'b1;
    chk(0, 0, 4, 1, "abort_lr");
    R = 1'b0;

    // Hazard ignores brake
    do_reset();
    Haz = 1'b1; Brake = 1'b1;
    for (int i = 0; i < 4; i++) chk(0, t4[i], t4[i], 1, "hazard");
    Haz = 1'b0; Brake = 1'b0;
    chk(0, 0, 0, 0, "hazard_end");

    // Brake during a left sweep, then with no turn
    do_reset();
    L = 1'b1;
    chk(0, 1, 0, 1, "brake_sweep");
    Brake = 1'b1;
    chk(0, 3, 7, 1, "brake_sweep");
    chk(0, 7, 7, 1, "brake_sweep");
    L = 1'b0;
    chk(0, 7, 7, 0, "brake_idle");
    Brake = 1'b0;
    chk(0, 0, 0, 0, "brake_release");

    // Prescaled sweep (DIV=4 instance), then reset mid-sweep
    do_reset();
    L = 1'b1;
    for (int i = 0; i < 11; i++)
      chk(1, (i < 3) ? 0 : (i < 7) ? 1 : 3, 0, int'(i >= 3), "div4_sweep");
    Reset = 1'b1;
    chk(1, 0, 0, 0, "div4_reset");
    Reset = 1'b0;
    for (int i = 0; i < 4; i++) chk(1, (i < 3) ? 0 : 1, 0, int'(i == 3), "div4_after_reset");
    L = 1'b0;

    // Randomised traffic, checked only by the every-cycle model compare
    for (int i = 0; i < 4000; i++) begin
      Reset = ($urandom_range(0, 149) == 0);
      L     = ($urandom_range(0, 3) == 0);
      R     = ($urandom_range(0, 3) == 0);
      Haz   = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 5) == 0) Brake = ~Brake;
      @(posedge CLK);
      @(negedge CLK);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
